wb_slave_mem: RTL and testbench
===============================

WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data bus width (multiple of 8).
REQ-002 SHALL have parameter AWIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DEPTH, default 16, number of DWIDTH words (power of 2).
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each response (0..15).
REQ-005 SHALL have parameter RETRY_WORD, default 3, word index subject to retry injection.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port wb_cyc_i  input  1  bus cycle valid.
REQ-009 SHALL have port wb_stb_i  input  1  strobe.
REQ-010 SHALL have port wb_we_i  input  1  1=write, 0=read.
REQ-011 SHALL have port wb_adr_i  input  AWIDTH  byte address.
REQ-012 SHALL have port wb_sel_i  input  DWIDTH/8  byte-lane enables.
REQ-013 SHALL have port wb_dat_i  input  DWIDTH  write data.
REQ-014 SHALL have port wb_dat_o  output  DWIDTH  read data.
REQ-015 SHALL have port wb_ack_o  output  1  normal termination.
REQ-016 SHALL have port wb_err_o  output  1  error termination.
REQ-017 SHALL have port wb_rty_o  output  1  retry termination.
REQ-018 SHALL have port access_cnt  output  16  count of ack-terminated transfers.

Function
REQ-019 SHALL implement FSM IDLE, WAIT, RESP; request = wb_cyc_i & wb_stb_i.
REQ-020 IDLE: on request sampled at edge T, SHALL latch we, adr, sel, dat and go to WAIT with wait counter = WAIT_CYCLES.
REQ-021 WAIT: SHALL decrement counter each edge; at zero go to RESP; WAIT_CYCLES=0 goes straight to RESP at T+1.
REQ-022 Exactly one of ack/err/rty SHALL be high for exactly one cycle, registered, starting at edge T+1+WAIT_CYCLES; RESP returns to IDLE next edge.
REQ-023 Word index = latched adr >> log2(DWIDTH/8); index >= DEPTH, or adr not word-aligned, SHALL give err, no memory update.
REQ-024 In-range write SHALL update only lanes with sel bit set, at the ack edge; sel=0 still acks.
REQ-025 In-range read SHALL drive wb_dat_o = memory word during the ack cycle; wb_dat_o SHALL be 0 in all other cycles.
REQ-026 Loss of request (wb_cyc_i or wb_stb_i low) while in WAIT SHALL abort: return to IDLE, no response, no write, no count.
REQ-027 access_cnt SHALL increment on each ack, wrap 0xFFFF->0; err/rty SHALL not count.
REQ-028 Master SHALL drop request within one cycle after response; request still high in IDLE is a new transfer.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, wb_ack_o=wb_err_o=wb_rty_o=0, wb_dat_o=0, access_cnt=0, retry flag=0.
REQ-030 Memory contents SHALL reset to 0; reset mid-WAIT SHALL discard the pending transfer with no write.

Configuration
REQ-031 Macro WB_SLV_RETRY_INJECT_EN defined: accesses to word RETRY_WORD SHALL alternate rty then ack (flag starts at rty after reset, toggles per terminated access to that word); rty does no write.
REQ-032 Macro undefined: wb_rty_o SHALL be tied 0 and RETRY_WORD ignored.

Verification
REQ-033 Write 0xDEADBEEF to 0x0 sel=0xF, then read 0x0 -> ack each at T+3, read data 0xDEADBEEF, access_cnt=2.
REQ-034 Write 0x11223344 to 0x4 sel=0xF, write 0xAABBCCDD sel=0x5, read 0x4 -> 0x11BB33DD.
REQ-035 Read 0x40 (index 16) and 0x2 (misaligned) -> err one cycle each, wb_dat_o=0, access_cnt unchanged.
REQ-036 Drop wb_cyc_i one cycle after request to 0x8 write 0x55 -> no response; read 0x8 -> 0x0.
REQ-037 With WB_SLV_RETRY_INJECT_EN, read 0xC twice -> rty then ack; without macro -> ack both.
REQ-038 Assert rst_n low mid-WAIT of write to 0x0 -> outputs 0 immediately; after release read 0x0 -> 0x0.

Source files
------------

// File: rtl/wb_slave_mem_if.sv
// Wishbone classic bus bundle between a master and the wb_slave_mem slave.
// Signal names keep the slave-side _i/_o suffixes of the original port list.
interface wb_slave_mem_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) ();
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_we_i;
    logic [AWIDTH-1:0]     wb_adr_i;
    logic [DWIDTH/8-1:0]   wb_sel_i;
    logic [DWIDTH-1:0]     wb_dat_i;
    logic [DWIDTH-1:0]     wb_dat_o;
    logic                  wb_ack_o;
    logic                  wb_err_o;
    logic                  wb_rty_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone slave memory with programmable wait states, error on bad address and
// optional retry injection on one word (enable with WB_SLV_RETRY_INJECT_EN).
module wb_slave_mem #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int RETRY_WORD  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_slave_mem_if.slave wb,
    output logic [15:0] access_cnt
);
    localparam int NLANES = DWIDTH / 8;
    localparam int BSHIFT = (NLANES > 1) ? $clog2(NLANES) : 0;
    localparam int IWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWIDTH-1:0] ALIGN_MASK = AWIDTH'((64'd1 << BSHIFT) - 64'd1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          wait_cnt;
    logic                lat_we;
    logic [AWIDTH-1:0]   lat_adr;
    logic [NLANES-1:0]   lat_sel;
    logic [DWIDTH-1:0]   lat_dat;
    logic [DWIDTH-1:0]   mem [DEPTH];

    logic                req;
    logic                finish;
    logic [AWIDTH-1:0]   idx;
    logic [IWIDTH-1:0]   widx;
    logic                in_range;
    logic                do_rty;
    logic                ack_nxt;
    logic                err_nxt;
    logic                mem_wr;
    logic [DWIDTH-1:0]   dat_nxt;

    assign req      = wb.wb_cyc_i & wb.wb_stb_i;
    assign idx      = lat_adr >> BSHIFT;
    assign widx     = idx[IWIDTH-1:0];
    assign in_range = ((lat_adr & ALIGN_MASK) == '0) && (idx < AWIDTH'(DEPTH));
    // The transfer terminates on the edge that leaves WAIT with the request still held.
    assign finish   = (state == WAIT) && req && (wait_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = WAIT;
            WAIT:    if (!req) state_nxt = IDLE;
                     else if (wait_cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack_nxt = finish && in_range && !do_rty;
        err_nxt = finish && !in_range;
        mem_wr  = ack_nxt && lat_we;
        dat_nxt = '0;
        if (ack_nxt && !lat_we) dat_nxt = mem[widx];
    end

    // Request capture, wait countdown and the registered response/counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            lat_we      <= 1'b0;
            lat_adr     <= '0;
            lat_sel     <= '0;
            lat_dat     <= '0;
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
            wb.wb_dat_o <= '0;
            access_cnt  <= '0;
        end else begin
            if (state == IDLE && req) begin
                wait_cnt <= 4'(WAIT_CYCLES);
                lat_we   <= wb.wb_we_i;
                lat_adr  <= wb.wb_adr_i;
                lat_sel  <= wb.wb_sel_i;
                lat_dat  <= wb.wb_dat_i;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            wb.wb_ack_o <= ack_nxt;
            wb.wb_err_o <= err_nxt;
            wb.wb_dat_o <= dat_nxt;
            if (ack_nxt) access_cnt <= access_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
        end else if (mem_wr) begin
            for (int b = 0; b < NLANES; b++)
                if (lat_sel[b]) mem[widx][b*8 +: 8] <= lat_dat[b*8 +: 8];
        end
    end

`ifdef WB_SLV_RETRY_INJECT_EN
    // retry_flag low means the next access to RETRY_WORD is answered with rty.
    logic retry_flag;
    logic retry_hit;
    assign retry_hit = in_range && (idx == AWIDTH'(RETRY_WORD));
    assign do_rty    = retry_hit && !retry_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_flag  <= 1'b0;
            wb.wb_rty_o <= 1'b0;
        end else begin
            wb.wb_rty_o <= finish && do_rty;
            if (finish && retry_hit) retry_flag <= ~retry_flag;
        end
    end
`else
    logic unused_retry_word;
    assign unused_retry_word = ^32'(RETRY_WORD);
    assign do_rty            = 1'b0;
    assign wb.wb_rty_o       = 1'b0;
`endif
endmodule

// File: tb/tb_wb_slave_mem.sv
// Self-checking bench for wb_slave_mem: vector table through a scoreboard plus
// hand-written abort and reset-during-wait sequences.
module tb_wb_slave_mem;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [2:0] ACK = 3'b100;
    localparam logic [2:0] ERR = 3'b010;
    localparam logic [2:0] RTY = 3'b001;
    localparam logic [2:0] RTY_OR_ACK =
`ifdef WB_SLV_RETRY_INJECT_EN
        3'b001;
`else
        3'b100;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] access_cnt;

    always #5 clk = ~clk;

    wb_slave_mem_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    wb_slave_mem #(
        .DWIDTH(DW), .AWIDTH(AW), .DEPTH(16), .WAIT_CYCLES(2), .RETRY_WORD(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wb(bus),
        .access_cnt(access_cnt)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [2:0]  exp_resp;
        logic [31:0] exp_dat;
    } vec_t;

    typedef struct {
        logic [2:0]  resp;
        logic [31:0] dat;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    vec_t        vecs[18];
    logic [15:0] model_cnt;
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] respBits();
        return {29'd0, bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o};
    endfunction

    // Runs one transfer: pushes the expectation, drives the request and compares on response.
    task automatic applyStimulus(input string name, input logic we, input logic [31:0] adr,
                                 input logic [3:0] sel, input logic [31:0] dat,
                                 input logic [2:0] exp_resp, input logic [31:0] exp_dat);
        exp_t        e;
        int          lat;
        logic        seen;
        logic [31:0] got_resp;
        logic [31:0] got_dat;
        if (exp_resp == ACK) model_cnt = model_cnt + 16'd1;
        e.resp = exp_resp;
        e.dat  = exp_dat;
        e.cnt  = model_cnt;
        exp_q.push_back(e);

        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_sel_i = sel;
        bus.wb_dat_i = dat;
        @(posedge clk);
        lat      = 0;
        seen     = 1'b0;
        got_resp = '0;
        got_dat  = '0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (respBits() != 0) begin
                seen     = 1'b1;
                got_resp = respBits();
                got_dat  = bus.wb_dat_o;
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;

        e = exp_q.pop_front();
        if (!seen) begin
            checkOutput({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({name, " latency"}, 32'(lat), 32'd3);
            checkOutput({name, " resp"}, got_resp, {29'd0, e.resp});
            checkOutput({name, " dat"}, got_dat, e.dat);
        end
        @(posedge clk);
        #1;
        checkOutput({name, " one-cycle"}, respBits() | {31'd0, |bus.wb_dat_o}, 32'd0);
        checkOutput({name, " cnt"}, {16'd0, access_cnt}, {16'd0, e.cnt});
    endtask

    initial begin
        logic seen_any;
        rst_n        = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_dat_i = '0;
        model_cnt    = '0;

        vecs[0]  = '{1'b1, 32'h00, 4'hF, 32'hDEADBEEF, ACK, 32'h0};
        vecs[1]  = '{1'b0, 32'h00, 4'hF, 32'h0,        ACK, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h04, 4'hF, 32'h11223344, ACK, 32'h0};
        vecs[3]  = '{1'b1, 32'h04, 4'h5, 32'hAABBCCDD, ACK, 32'h0};
        vecs[4]  = '{1'b0, 32'h04, 4'hF, 32'h0,        ACK, 32'h11BB33DD};
        vecs[5]  = '{1'b0, 32'h40, 4'hF, 32'h0,        ERR, 32'h0};
        vecs[6]  = '{1'b0, 32'h02, 4'hF, 32'h0,        ERR, 32'h0};
        vecs[7]  = '{1'b1, 32'h08, 4'h0, 32'hFFFFFFFF, ACK, 32'h0};
        vecs[8]  = '{1'b0, 32'h08, 4'hF, 32'h0,        ACK, 32'h0};
        vecs[9]  = '{1'b0, 32'h0C, 4'hF, 32'h0,        RTY_OR_ACK, 32'h0};
        vecs[10] = '{1'b0, 32'h0C, 4'hF, 32'h0,        ACK, 32'h0};
        vecs[11] = '{1'b1, 32'h0C, 4'hF, 32'h12345678, RTY_OR_ACK, 32'h0};
        vecs[12] = '{1'b1, 32'h0C, 4'hF, 32'h12345678, ACK, 32'h0};
        vecs[13] = '{1'b1, 32'h3C, 4'hF, 32'hCAFEF00D, ACK, 32'h0};
        vecs[14] = '{1'b0, 32'h3C, 4'hF, 32'h0,        ACK, 32'hCAFEF00D};
        vecs[15] = '{1'b0, 32'h3E, 4'hF, 32'h0,        ERR, 32'h0};
        vecs[16] = '{1'b1, 32'h10, 4'h8, 32'hA5FFFFFF, ACK, 32'h0};
        vecs[17] = '{1'b0, 32'h10, 4'hF, 32'h0,        ACK, 32'hA5000000};

        #12;
        checkOutput("reset resp", respBits(), 32'd0);
        checkOutput("reset dat", bus.wb_dat_o, 32'd0);
        checkOutput("reset cnt", {16'd0, access_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].sel,
                          vecs[i].dat, vecs[i].exp_resp, vecs[i].exp_dat);

        // Abort: request withdrawn one cycle into the wait.
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 32'h08;
        bus.wb_sel_i = 4'hF;
        bus.wb_dat_i = 32'h55;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.wb_cyc_i = 1'b0;
        seen_any = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (respBits() != 0) seen_any = 1'b1;
        end
        bus.wb_stb_i = 1'b0;
        checkOutput("abort no resp", {31'd0, seen_any}, 32'd0);
        checkOutput("abort cnt", {16'd0, access_cnt}, {16'd0, model_cnt});
        applyStimulus("abort readback", 1'b0, 32'h08, 4'hF, 32'h0, ACK, 32'h0);

        // Reset asserted while a write to word 0 is waiting.
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 32'h00;
        bus.wb_sel_i = 4'hF;
        bus.wb_dat_i = 32'hFFFFFFFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midwait rst resp", respBits(), 32'd0);
        checkOutput("midwait rst dat", bus.wb_dat_o, 32'd0);
        checkOutput("midwait rst cnt", {16'd0, access_cnt}, 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        model_cnt    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post rst rd0", 1'b0, 32'h00, 4'hF, 32'h0, ACK, 32'h0);
        applyStimulus("post rst rd4", 1'b0, 32'h04, 4'hF, 32'h0, ACK, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
